dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Data-memory bridge sitting directly downstream of the processor core's EM-stage memory interface.
- Consumes the core's registered word request (mem_addr/mem_oe/mem_we/mem_wdata) and returns mem_rdata/mem_valid/mem_ready.
- Serves an on-chip word RAM with fixed 1-cycle latency.
- Routes the IO region to a slow req/ack peripheral port, with a posted write buffer and blocking reads.

Parameters:
- RAM_SCALE, 12, log2 of RAM depth in 32-bit words; RAM occupies byte addresses 0 .. 4*2^RAM_SCALE-1, aliased below 0x8000_0000.
- WBUF_SCALE, 2, log2 of IO write-buffer depth (default 4 entries).
- INIT, 0, when 1 the RAM is preloaded from the program image at elaboration.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_addr  in  32  byte address from core; bits [1:0] ignored (word access)
- mem_oe  in  4  per-byte access enable; any bit set = request present
- mem_we  in  4  per-byte write enable; nonzero = write, zero with oe = read
- mem_wdata  in  32  write data, lane-aligned
- mem_rdata  out  32  full read word (core does sign/zero extension)
- mem_valid  out  1  read data on mem_rdata is valid this cycle
- mem_ready  out  1  bridge accepts a request presented on the next cycle
- io_addr  out  32  peripheral address
- io_wdata  out  32  peripheral write data
- io_we  out  4  peripheral byte write enables; 0 = read
- io_req  out  1  peripheral request, held until io_ack
- io_ack  in  1  peripheral completion, single-cycle pulse
- io_rdata  in  32  peripheral read data, valid with io_ack

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Region decode: mem_addr[31]==0 is RAM; mem_addr[31]==1 is IO.
- Reset values: mem_valid=0, mem_rdata=0, mem_ready=0 during rst, io_req=0, io_we=0, FSM=IDLE, write buffer empty, pending read cleared.
- A reset mid-transaction drops io_req immediately and discards buffered writes and the outstanding read.
- RAM write (cycle N): byte lanes with mem_we set are updated at the end of cycle N. There is no response.
- RAM read (cycle N): mem_rdata=RAM word and mem_valid=1 in cycle N+1. mem_valid is a one-cycle pulse.
- Read-during-write to the same RAM word in consecutive cycles returns the new data (write-first).
- mem_rdata holds its last value until the next read completes. The core may stall WB and re-sample it.
- IO write: pushed to the write buffer {addr, wdata, we} in the request cycle. There is no response (posted).
- IO read: latched as pending and mem_ready drops combinationally in the same cycle. mem_valid pulses the cycle after io_ack with mem_rdata=io_rdata.
- IO FSM states:
  - IDLE: if buffer non-empty go to WR; else if read pending go to RD.
  - WR: io_req=1, driven from buffer head. On io_ack, pop the entry and return to IDLE.
  - RD: entered only with the buffer empty, so reads are ordered after earlier writes. io_req=1, io_we=0. On io_ack, capture data, clear pending, and return to IDLE.
- io_addr/io_wdata/io_we are stable while io_req=1. io_req is registered.
- mem_ready=0 when any of: rst; IO read pending or in RD; buffer occupancy >= depth-1.
  - The depth-1 threshold covers the one request that may already be in flight.
- Simultaneous push and pop: occupancy unchanged. Pointers wrap modulo depth.
- A request arriving while mem_ready was low in the previous cycle is a protocol violation. The bench asserts on it; the RTL does not handle it.
- Back-to-back RAM requests are accepted every cycle with no bubble.

Decomposition:
- Shared package/header:
  - region decode constant IO_BASE=0x8000_0000;
  - FSM encodings IDLE/WR/RD;
  - write-buffer entry width (68 bits).
- Sub-module sync_fifo (parameter WIDTH, SCALE):
  - push/pop/full/empty/count;
  - registered pointers;
  - instantiated once for the write buffer.
- The RAM is an inline byte-enabled array in dmem_bridge.

Test Plan:
- Write 0xDEADBEEF to 0x100 with we=4'b1111, then read 0x100 in the next cycle -> mem_valid=1 two cycles after the write, mem_rdata=0xDEADBEEF.
- Write 0x000000AA to 0x104 with we=4'b0001 over prior 0x11223344 -> read returns 0x112233AA.
- Three IO writes to 0x8000_0000..08, then an IO read of 0x8000_0010 with io_ack delayed 3 cycles each:
  - io_req sequence is the three writes in order, then the read;
  - mem_ready is low from the read cycle until mem_valid;
  - mem_rdata equals io_rdata=0xCAFE0001.
- Four IO writes issued every cycle while io_ack is held low -> mem_ready falls when occupancy reaches 3; no entry is lost; all four are delivered after acks resume.
- Assert rst during the RD state with io_req=1 -> next cycle io_req=0, mem_valid=0, buffer empty; a subsequent RAM read at 0x0 works normally.
- Alternating RAM read/write every cycle for 64 cycles against a reference model -> every read's mem_valid arrives exactly 1 cycle later with matching data.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: region decode, IO FSM states
// and the layout of a posted IO write held in the write buffer.
package dmem_bridge_pkg;

  localparam logic [31:0] IO_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } io_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } wbuf_entry_t;

  localparam int unsigned WBUF_W = $bits(wbuf_entry_t);

  function automatic logic is_io(input logic [31:0] addr);
    return (addr & IO_BASE) != '0;
  endfunction

endpackage

// File: rtl/dmem_bridge_fifo.sv
// Synchronous FIFO with registered pointers and a fall-through head word.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SCALE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [SCALE:0]   count
);

  localparam int unsigned DEPTH = 1 << SCALE;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SCALE-1:0] wr_ptr;
  logic [SCALE-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (SCALE + 1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + SCALE'(1);
      if (do_pop)  rd_ptr <= rd_ptr + SCALE'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (SCALE + 1)'(1);
        2'b01:   count <= count - (SCALE + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: 1-cycle on-chip word RAM below IO_BASE, and a req/ack
// peripheral port above it with posted writes and blocking, write-ordered reads.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned RAM_SCALE  = 12,
  parameter int unsigned WBUF_SCALE = 2,
  parameter int unsigned INIT       = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_oe,
  input  logic [3:0]  mem_we,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_ready,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_we,
  output logic        io_req,
  input  logic        io_ack,
  input  logic [31:0] io_rdata
);

  localparam int unsigned         RAM_DEPTH = 1 << RAM_SCALE;
  localparam logic [WBUF_SCALE:0] WB_THRESH = (WBUF_SCALE + 1)'((1 << WBUF_SCALE) - 1);

  logic [31:0]          ram [RAM_DEPTH];
  logic [RAM_SCALE-1:0] ram_idx;
  logic                 req, wr, io_sel;
  logic                 ram_rd, ram_wr, io_rd_req, wb_push, wb_pop, rd_done;
  logic                 rd_pend;
  logic [31:0]          rd_addr;
  io_state_t            state;
  wbuf_entry_t          wb_in, wb_head;
  logic                 wb_full, wb_empty;
  logic [WBUF_SCALE:0]  wb_count;
  logic                 unused_bits;

  assign req       = |mem_oe;
  assign wr        = |mem_we;
  assign io_sel    = is_io(mem_addr);
  assign ram_idx   = mem_addr[RAM_SCALE+1:2];
  assign ram_wr    = !rst && req && !io_sel && wr;
  assign ram_rd    = !rst && req && !io_sel && !wr;
  assign io_rd_req = req && io_sel && !wr;
  assign wb_push   = !rst && req && io_sel && wr;
  assign wb_pop    = (state == WR) && io_ack;
  assign rd_done   = (state == RD) && io_ack;
  assign wb_in     = '{addr: mem_addr, wdata: mem_wdata, we: mem_we};

  // One more request may already be in flight when ready drops, hence depth-1.
  assign mem_ready = !(rst || io_rd_req || rd_pend || state == RD || wb_count >= WB_THRESH);

  // With INIT set the program image is placed into ram by the load flow; the array has no reset.
  assign unused_bits = wb_full | (INIT != 0);

  sync_fifo #(
    .WIDTH (WBUF_W),
    .SCALE (WBUF_SCALE)
  ) u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .push  (wb_push),
    .pop   (wb_pop),
    .wdata (wb_in),
    .rdata (wb_head),
    .full  (wb_full),
    .empty (wb_empty),
    .count (wb_count)
  );

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[ram_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_valid <= ram_rd || rd_done;
      if (ram_rd) begin
        mem_rdata <= ram[ram_idx];
      end else if (rd_done) begin
        mem_rdata <= io_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_addr <= '0;
    end else if (io_rd_req) begin
      rd_pend <= 1'b1;
      rd_addr <= mem_addr;
    end else if (rd_done) begin
      rd_pend <= 1'b0;
    end
  end

  // Writes drain before a pending read is issued, keeping IO accesses in program order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      io_req   <= 1'b0;
      io_we    <= '0;
      io_addr  <= '0;
      io_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!wb_empty) begin
            state    <= WR;
            io_req   <= 1'b1;
            io_addr  <= wb_head.addr;
            io_wdata <= wb_head.wdata;
            io_we    <= wb_head.we;
          end else if (rd_pend) begin
            state    <= RD;
            io_req   <= 1'b1;
            io_addr  <= rd_addr;
            io_wdata <= '0;
            io_we    <= '0;
          end
        end
        WR: begin
          if (io_ack) begin
            state  <= IDLE;
            io_req <= 1'b0;
            io_we  <= '0;
          end
        end
        RD: begin
          if (io_ack) begin
            state  <= IDLE;
            io_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: a transaction-level model of RAM contents,
// IO ordering and ready/valid timing, compared against the DUT every cycle.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [3:0]  mem_oe;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_we;
  logic        io_req;
  logic        io_ack;
  logic [31:0] io_rdata;

  always #5 clk = ~clk;

  dmem_bridge #(
    .RAM_SCALE  (12),
    .WBUF_SCALE (2),
    .INIT       (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_we     (io_we),
    .io_req    (io_req),
    .io_ack    (io_ack),
    .io_rdata  (io_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    bit          rd;
  } io_txn_t;

  int          checks = 0;
  int          errors = 0;

  // model state
  logic [31:0] mram [int unsigned];
  io_txn_t     exp_io[$];
  io_txn_t     cur;
  bit          serving = 0, gap = 0;
  bit          ack_next = 0, ack_hold = 0;
  logic [31:0] ack_data_next = 32'h0;
  int unsigned ack_delay = 1, ack_cnt = 0;
  int unsigned writes_out = 0, read_out = 0, delivered_wr = 0;
  bit          exp_valid = 0, exp_known = 1, ready_prev = 0;
  logic [31:0] exp_rdata = 32'h0;

  function automatic logic [31:0] periph(input logic [31:0] a);
    return (a == 32'h8000_0010) ? 32'hCAFE_0001 : (a ^ 32'h3C3C_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    io_ack   = ack_next;
    io_rdata = ack_next ? ack_data_next : 32'hDEAD_0000;
  end

  // Model and per-cycle compare
  initial forever begin
    bit          req_now, wr_now, io_now, ready_now, nv, nk;
    logic [31:0] nd, w;
    int unsigned widx;
    @(negedge clk);
    req_now   = |mem_oe;
    wr_now    = |mem_we;
    io_now    = mem_addr[31];
    widx      = int'(mem_addr[13:2]);
    ready_now = !(rst || read_out != 0 || (req_now && io_now && !wr_now) || writes_out >= 3);
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, ready_now});
    chk("mem_valid", {31'b0, mem_valid}, {31'b0, exp_valid});
    if (exp_known) chk("mem_rdata", mem_rdata, exp_rdata);
    if (!rst && req_now && !ready_prev) begin
      errors++;
      $display("FAIL protocol: request while ready was low at %0t", $time);
    end
    nv = 0; nd = exp_rdata; nk = exp_known;
    if (rst) begin
      serving = 0; gap = 0; ack_next = 0;
    end else if (serving) begin
      chk("io_req_held", {31'b0, io_req}, 32'd1);
      chk("io_addr_stable", io_addr, cur.addr);
      chk("io_we_stable", {28'b0, io_we}, {28'b0, cur.we});
      if (!cur.rd) chk("io_wdata_stable", io_wdata, cur.wdata);
      if (io_ack) begin
        serving = 0; gap = 1; ack_next = 0;
        if (cur.rd) begin
          read_out = 0; nv = 1; nd = periph(cur.addr); nk = 1;
        end else begin
          writes_out--; delivered_wr++;
        end
      end else if (!ack_hold && !ack_next) begin
        if (ack_cnt > 0) ack_cnt--;
        if (ack_cnt == 0) begin
          ack_next = 1;
          ack_data_next = cur.rd ? periph(cur.addr) : 32'hFFFF_FFFF;
        end
      end
    end else if (gap) begin
      chk("io_req_drop", {31'b0, io_req}, 32'd0);
      gap = 0;
    end else if (io_req) begin
      if (exp_io.size() == 0) begin
        checks++; errors++;
        $display("FAIL io_unexpected: got io_req=1 addr %h want no request", io_addr);
        serving = 1; cur = '{addr: io_addr, wdata: io_wdata, we: io_we, rd: (io_we == 0)};
      end else begin
        cur = exp_io.pop_front();
        chk("io_order_addr", io_addr, cur.addr);
        chk("io_order_we", {28'b0, io_we}, {28'b0, cur.we});
        if (!cur.rd) chk("io_order_wdata", io_wdata, cur.wdata);
        serving = 1;
      end
      ack_cnt = ack_delay - 1;
      if (ack_cnt == 0 && !ack_hold) begin
        ack_next = 1;
        ack_data_next = cur.rd ? periph(cur.addr) : 32'hFFFF_FFFF;
      end
    end
    if (rst) begin
      exp_valid = 0; exp_rdata = 32'h0; exp_known = 1;
      writes_out = 0; read_out = 0; exp_io.delete();
    end else begin
      if (req_now) begin
        if (!io_now) begin
          if (wr_now) begin
            w = mram.exists(widx) ? mram[widx] : 32'h0;
            for (int b = 0; b < 4; b++) if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mram[widx] = w;
          end else begin
            nv = 1;
            nk = mram.exists(widx);
            nd = nk ? mram[widx] : 32'h0;
          end
        end else if (wr_now) begin
          exp_io.push_back('{addr: mem_addr, wdata: mem_wdata, we: mem_we, rd: 1'b0});
          writes_out++;
        end else begin
          exp_io.push_back('{addr: mem_addr, wdata: 32'h0, we: 4'h0, rd: 1'b1});
          read_out = 1;
        end
      end
      exp_valid = nv; exp_rdata = nd; exp_known = nk;
    end
    ready_prev = ready_now;
  end

  task automatic set_idle();
    mem_oe = 4'h0; mem_we = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
  endtask

  task automatic issue(input logic [3:0] oe, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    @(negedge clk);
    while (!mem_ready && n < 200) begin
      @(posedge clk); #1; set_idle();
      @(negedge clk); n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got mem_ready=0 for 200 cycles want 1");
    end
    @(posedge clk); #1;
    mem_oe = oe; mem_we = we; mem_addr = addr; mem_wdata = wdata;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1; set_idle();
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk); #1; set_idle();
    do begin
      @(negedge clk); #1; n++;
    end while (!(exp_io.size() == 0 && !serving && writes_out == 0 && read_out == 0) && n < 300);
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d outstanding writes want 0", writes_out);
    end
  endtask

  initial begin
    rst = 1'b1; io_ack = 1'b0; io_rdata = 32'h0;
    set_idle();
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", {31'b0, mem_valid}, 32'd0);
    chk("reset_rdata", mem_rdata, 32'h0);
    chk("reset_io_req", {31'b0, io_req}, 32'd0);
    chk("reset_io_we", {28'b0, io_we}, 32'd0);
    chk("reset_ready", {31'b0, mem_ready}, 32'd1);

    // RAM write then read next cycle, plus top-of-RAM alias
    issue(4'hF, 4'hF, 32'h0000_0000, 32'h0BAD_F00D);
    issue(4'hF, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
    issue(4'hF, 4'h0, 32'h0000_0100, 32'h0);
    idle_cycle();
    chk("ram_wr_rd_valid", {31'b0, mem_valid}, 32'd1);
    chk("ram_wr_rd_data", mem_rdata, 32'hDEAD_BEEF);
    issue(4'hF, 4'hF, 32'h0000_3FFC, 32'h5555_AAAA);
    issue(4'hF, 4'h0, 32'h0000_7FFC, 32'h0);
    idle_cycle();
    chk("ram_alias_data", mem_rdata, 32'h5555_AAAA);
    idle_cycle();
    chk("rdata_hold", mem_rdata, 32'h5555_AAAA);

    // Partial-lane write
    issue(4'hF, 4'hF, 32'h0000_0104, 32'h1122_3344);
    issue(4'h1, 4'h1, 32'h0000_0104, 32'h0000_00AA);
    issue(4'hF, 4'h0, 32'h0000_0104, 32'h0);
    idle_cycle();
    chk("ram_byte_lane", mem_rdata, 32'h1122_33AA);

    // Posted writes followed by an ordered blocking read, ack delayed 3
    ack_delay = 3; delivered_wr = 0;
    for (int i = 0; i < 3; i++)
      issue(4'hF, 4'hF, 32'h8000_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    issue(4'hF, 4'h0, 32'h8000_0010, 32'h0);
    drain();
    @(negedge clk);
    chk("io_rd_valid", {31'b0, mem_valid}, 32'd1);
    chk("io_rd_data", mem_rdata, 32'hCAFE_0001);
    chk("io_wr_count", delivered_wr, 32'd3);

    // Buffer fill with acks stalled
    ack_delay = 1; ack_hold = 1; delivered_wr = 0;
    for (int i = 0; i < 4; i++)
      issue(4'hF, 4'hF, 32'h8000_0020 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    @(negedge clk);
    chk("wbuf_ready_low", {31'b0, mem_ready}, 32'd0);
    idle_cycle(); idle_cycle(); idle_cycle();
    ack_hold = 0;
    drain();
    chk("wbuf_delivered", delivered_wr, 32'd4);

    // Reset while the read is on the bus
    ack_hold = 1;
    issue(4'hF, 4'h0, 32'h8000_0040, 32'h0);
    begin
      int n = 0;
      @(posedge clk); #1; set_idle();
      do begin @(negedge clk); n++; end while (!io_req && n < 50);
      chk("rd_io_req_seen", {31'b0, io_req}, 32'd1);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; ack_hold = 0;
    @(negedge clk);
    chk("rst_io_req", {31'b0, io_req}, 32'd0);
    chk("rst_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_ready", {31'b0, mem_ready}, 32'd1);
    issue(4'hF, 4'h0, 32'h0000_0000, 32'h0);
    idle_cycle();
    chk("post_rst_data", mem_rdata, 32'h0BAD_F00D);

    // Alternating RAM write/read for 64 cycles
    for (int i = 0; i < 32; i++) begin
      logic [31:0] a;
      a = 32'h0000_0200 + 32'(4 * (i % 8));
      issue(4'hF, (i < 8) ? 4'hF : 4'(i % 15 + 1), a, 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101));
      issue(4'hF, 4'h0, a, 32'h0);
    end
    idle_cycle();
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got no finish by %0t want finish", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
